// File: rtl/spi_reg_pkg.sv
// Shared types and command-byte field definitions for the SPI register controller.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WR   = 2'd2,
        RD   = 2'd3
    } state_t;

    localparam int REG_WIDTH     = 8;
    localparam int CMD_WR_BIT    = 7;
    localparam int CMD_FIELD_MSB = 6;  // bits [6:0] carry the start address field

endpackage

// File: rtl/spi_reg_bank.sv
// NUM_REGS x WIDTH read/write register storage with one write port and a flattened view.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = REG_WIDTH,
    parameter int BA_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [BA_W-1:0]           addr,
    input  logic [WIDTH-1:0]          wdata,
    output logic [NUM_REGS*WIDTH-1:0] regs
);

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we && addr == BA_W'(i)) begin
                    regs[i*WIDTH +: WIDTH] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI transaction controller: command parse, burst write to RW bank, burst read of RW/status.
// Build option SPI_REG_CTRL_AUTOINC_EN: address increments per data byte; otherwise fixed per frame.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = REG_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      frame_end,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic [7:0]                tx_data,
    output logic                      tx_load,
    input  logic [NUM_REGS*WIDTH-1:0] stat_reg,
    output logic [NUM_REGS*WIDTH-1:0] rw_reg,
    output logic                      wr_strobe,
    output logic                      addr_err,
    output logic                      busy,
    output state_t                    dbg_state
);

    localparam int SPAN   = 2 * NUM_REGS;
    localparam int ADDR_W = $clog2(SPAN);
    localparam int BA_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // Pulse protocol: rx_valid, tx_load, wr_strobe and addr_err are one-cycle
    // strobes with no backpressure; every response appears exactly one clock
    // after the rx_valid that caused it, and tx_data holds between loads.

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                oor_q, oor_d;
    logic [7:0]          tx_data_d;
    logic                tx_load_d, wr_strobe_d, addr_err_d;
    logic                bank_we;

    logic [ADDR_W-1:0]   cmd_addr;
    logic                cmd_oor;
    logic [ADDR_W-1:0]   next_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_oor;
    logic [WIDTH-1:0]    rd_data;

    // Out of range covers both nonzero high field bits and non-power-of-two maps.
    assign cmd_addr = rx_data[ADDR_W-1:0];
    assign cmd_oor  = ({1'b0, rx_data[CMD_FIELD_MSB:0]} >= 8'(SPAN));

`ifdef SPI_REG_CTRL_AUTOINC_EN
    assign next_addr = (addr_q == ADDR_W'(SPAN - 1)) ? '0 : addr_q + 1'b1;
`else
    assign next_addr = addr_q;
`endif

    // The command byte reads its own start address; later dummies read the advanced one.
    assign rd_addr = (state_q == CMD) ? cmd_addr : next_addr;
    assign rd_oor  = (state_q == CMD) ? cmd_oor  : oor_q;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = rw_reg[i*WIDTH +: WIDTH];
            end
            if (rd_addr == ADDR_W'(i + NUM_REGS)) begin
                rd_data = stat_reg[i*WIDTH +: WIDTH];
            end
        end
        if (rd_oor) begin
            rd_data = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        oor_d       = oor_q;
        tx_load_d   = 1'b0;
        wr_strobe_d = 1'b0;
        addr_err_d  = 1'b0;
        bank_we     = 1'b0;

        if (frame_start) begin
            // Abort/restart: any byte arriving alongside is dropped.
            state_d = CMD;
        end else begin
            if (rx_valid) begin
                case (state_q)
                    CMD: begin
                        addr_d  = cmd_addr;
                        oor_d   = cmd_oor;
                        state_d = rx_data[CMD_WR_BIT] ? WR : RD;
                        if (!rx_data[CMD_WR_BIT]) begin
                            tx_load_d  = 1'b1;
                            addr_err_d = cmd_oor;
                        end
                    end
                    WR: begin
                        if (!oor_q && addr_q < ADDR_W'(NUM_REGS)) begin
                            bank_we     = 1'b1;
                            wr_strobe_d = 1'b1;
                        end else begin
                            addr_err_d = 1'b1;
                        end
                        addr_d = next_addr;
                    end
                    RD: begin
                        addr_d     = next_addr;
                        tx_load_d  = 1'b1;
                        addr_err_d = oor_q;
                    end
                    default: ;
                endcase
            end
            if (frame_end) begin
                state_d = IDLE;
            end
        end
    end

    assign tx_data_d = tx_load_d ? rd_data : tx_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            oor_q     <= 1'b0;
            tx_data   <= '0;
            tx_load   <= 1'b0;
            wr_strobe <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            oor_q     <= oor_d;
            tx_data   <= tx_data_d;
            tx_load   <= tx_load_d;
            wr_strobe <= wr_strobe_d;
            addr_err  <= addr_err_d;
        end
    end

    spi_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .WIDTH    (WIDTH),
        .BA_W     (BA_W)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (bank_we),
        .addr  (addr_q[BA_W-1:0]),
        .wdata (rx_data),
        .regs  (rw_reg)
    );

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
